regfile_sstate: RTL and testbench
=================================

REGFILE_SSTATE -- requirements
Module: regfile_sstate

Interface
REQ-001 The block SHALL have parameter RD_LAT, default 1, meaning cycles from the sampled port-B address to valid qb (legal values 1..2).
REQ-002 The block SHALL have parameter FIFO_DEPTH, default 4, meaning the save-data buffer depth (power of two, at least RD_LAT+1).
REQ-003 The block SHALL have port sys_clk, input, width 1: the single clock; all logic on its rising edge.
REQ-004 The block SHALL have port reset, input, width 1: asynchronous, active-high reset.
REQ-005 The block SHALL have port start_save, input, width 1: pulse that starts a dump of all 64 registers.
REQ-006 The block SHALL have port start_load, input, width 1: pulse that starts a restore of all 64 registers.
REQ-007 The block SHALL have port busy, output, width 1: an operation is in progress.
REQ-008 The block SHALL have port done, output, width 1: one-cycle pulse marking completion.
REQ-009 The block SHALL have ports req (output, 1) and gnt (input, 1): port-B ownership request and grant.
REQ-010 The block SHALL have ports ab (output, 6), db (output, 32), nweb (output, 1), clkb (output, 1) and qb (input, 32): the register-file port-B connection.
REQ-011 The block SHALL have ports s_data (output, 32), s_valid (output, 1) and s_ready (input, 1): the save stream.
REQ-012 The block SHALL have ports l_data (input, 32), l_valid (input, 1) and l_ready (output, 1): the load stream.

Function
REQ-013 States SHALL be IDLE, REQ, SAVE, LOAD and FIN.
- IDLE -> REQ on start_save or start_load, with the operation latched.
- If both pulses arrive in the same cycle, save SHALL win.
- Start pulses outside IDLE SHALL be ignored.
REQ-014 REQ SHALL assert req and hold it through FIN.
- It SHALL move to SAVE or LOAD on the first cycle gnt=1.
- gnt is sampled only in REQ; the arbiter does not revoke it before done.
REQ-015 busy SHALL be 1 in every state except IDLE.
REQ-016 Whenever the block is not issuing an access, port B SHALL be idle: nweb=1, clkb=0.
REQ-017 SAVE read issue:
- A 6-bit address counter starts at 0.
- A read is issued (ab=counter, clkb=1, nweb=1) only when free FIFO entries exceed in-flight reads.
- The counter increments on each issue; it stops after address 63 and SHALL NOT wrap.
REQ-018 SAVE capture:
- Each read's qb SHALL be pushed into the FIFO exactly RD_LAT cycles after issue, tracked by an RD_LAT-stage valid shift register.
- The FIFO SHALL never overflow.
REQ-019 Save stream:
- s_valid = FIFO not empty; s_data = FIFO head.
- A pop occurs when s_valid and s_ready are both 1.
- Words leave in address order 0..63.
- s_valid and s_data SHALL stay stable while s_ready=0.
REQ-020 SAVE -> FIN when the 64th word is popped.
REQ-021 LOAD:
- l_ready=1 while fewer than 64 words have been accepted.
- A word accepted in cycle N (l_valid and l_ready both 1) SHALL be written in cycle N+1 with ab=counter, db=word, nweb=0, clkb=1; the counter then increments.
- Back-to-back acceptance SHALL sustain one write per cycle.
REQ-022 LOAD -> FIN in the cycle the 64th write is driven.
REQ-023 FIN SHALL pulse done for one cycle, then the next state SHALL be IDLE with req=0.
REQ-024 Throughput: with gnt=1 and s_ready held at 1, a save SHALL complete within 64+RD_LAT+3 cycles of start_save.

Reset
REQ-025 While reset=1, outputs SHALL be forced asynchronously to: busy=0, done=0, req=0, s_valid=0, l_ready=0, nweb=1, clkb=0, ab=0, db=0, s_data=0.
REQ-026 Reset mid-operation SHALL abort the operation: FIFO, counters and in-flight tracking cleared, state IDLE, and no further port-B write after reset asserts.

Structure
REQ-027 The state encoding and the constants NREGS=64, AW=6 and DW=32 SHALL live in the shared package sstate_pkg.
REQ-028 The save buffer SHALL be the sub-module sstate_fifo: synchronous, same clock and reset, with push, pop, full, empty and count.

Verification
REQ-029 Save, RD_LAT=1, gnt after 3 cycles, s_ready=1, register k preloaded with 0xA5000000+k -> 64 words 0xA5000000..0xA500003F in order, one done pulse, nweb never 0.
REQ-030 Save with s_ready toggling 1,0,0,1 and RD_LAT=2 -> identical word sequence, no loss or duplication, no FIFO overflow, s_data stable while s_ready=0.
REQ-031 Load of 0x1000+k with l_valid gaps -> 64 writes, nweb=0 only on write cycles, ab=k with db=0x1000+k; a subsequent save returns the same values.
REQ-032 start_save and start_load in the same cycle -> save runs; a start_load during busy is ignored; exactly one done pulse.
REQ-033 reset asserted after 20 load writes -> outputs at reset values immediately, registers 20..63 unmodified, a new save after reset works.

Source files
------------

// File: rtl/sstate_pkg.sv
// sstate_pkg: shared constants and FSM encoding for the register-file save/restore engine
package sstate_pkg;
  localparam int NREGS = 64;
  localparam int AW = 6;
  localparam int DW = 32;
  typedef enum logic [2:0] {IDLE, REQ, SAVE, LOAD, FIN} state_t;
endpackage

// File: rtl/sstate_fifo.sv
// sstate_fifo: small synchronous FIFO buffering read data ahead of the save stream
module sstate_fifo #(
  parameter int DEPTH = 4,
  parameter int W = 32
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  logic [W-1:0]           din,
  input  logic                   pop,
  output logic [W-1:0]           dout,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);
  localparam int PW = $clog2(DEPTH);
  logic [W-1:0] mem [DEPTH];
  logic [PW-1:0] wp_q, wp_d, rp_q, rp_d;
  logic [PW:0] cnt_q, cnt_d;
  logic do_push, do_pop;
  // guarded handshakes and pointer/count next values
  always_comb begin
    full = cnt_q == (PW+1)'(DEPTH);
    empty = cnt_q == '0;
    do_push = push && !full;
    do_pop = pop && !empty;
    wp_d = wp_q + PW'(do_push);
    rp_d = rp_q + PW'(do_pop);
    cnt_d = cnt_q + (PW+1)'(do_push) - (PW+1)'(do_pop);
    dout = mem[rp_q];
    count = cnt_q;
  end
  // storage array needs no reset: only entries below the count are ever read out
  always_ff @(posedge clk)
    if (do_push) mem[wp_q] <= din;
  // pointers and occupancy
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      wp_q <= '0;
      rp_q <= '0;
      cnt_q <= '0;
    end else begin
      wp_q <= wp_d;
      rp_q <= rp_d;
      cnt_q <= cnt_d;
    end
endmodule

// File: rtl/regfile_sstate.sv
// regfile_sstate: dumps or restores all 64 registers of a register file through its port B
module regfile_sstate
  import sstate_pkg::*;
#(
  parameter int RD_LAT = 1,
  parameter int FIFO_DEPTH = 4
) (
  input  logic          sys_clk,
  input  logic          reset,
  input  logic          start_save,
  input  logic          start_load,
  output logic          busy,
  output logic          done,
  output logic          req,
  input  logic          gnt,
  output logic [AW-1:0] ab,
  output logic [DW-1:0] db,
  output logic          nweb,
  output logic          clkb,
  input  logic [DW-1:0] qb,
  output logic [DW-1:0] s_data,
  output logic          s_valid,
  input  logic          s_ready,
  input  logic [DW-1:0] l_data,
  input  logic          l_valid,
  output logic          l_ready
);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam logic [AW:0] LAST = (AW+1)'(NREGS - 1);
  state_t state_q, state_d;
  logic op_save_q, op_save_d;
  logic [AW:0] addr_q, addr_d, pops_q, pops_d, accs_q, accs_d;
  logic [RD_LAT-1:0] vld_q, vld_d;
  logic wr_q, wr_d;
  logic [DW-1:0] wdat_q, wdat_d;
  logic [CW-1:0] f_count;
  logic f_full, f_empty;
  logic [DW-1:0] f_head;
  logic [CW:0] f_free, in_flight;
  logic idle, issue, push, pop, accept;
  sstate_fifo #(.DEPTH(FIFO_DEPTH), .W(DW)) u_fifo (
    .clk(sys_clk),
    .rst(reset),
    .push(push),
    .din(qb),
    .pop(pop),
    .dout(f_head),
    .full(f_full),
    .empty(f_empty),
    .count(f_count)
  );
  // reads issue only when every in-flight read is guaranteed a free FIFO slot on arrival
  always_comb begin
    idle = state_q == IDLE;
    f_free = (CW+1)'(FIFO_DEPTH) - {1'b0, f_count};
    in_flight = (CW+1)'($countones(vld_q));
    issue = state_q == SAVE && !addr_q[AW] && !f_full && f_free > in_flight;
    push = vld_q[RD_LAT-1];
    s_valid = !f_empty;
    s_data = f_empty ? '0 : f_head;
    pop = s_valid && s_ready;
    l_ready = state_q == LOAD && !accs_q[AW];
    accept = l_valid && l_ready;
    busy = !idle;
    req = !idle;
    done = state_q == FIN;
    nweb = !wr_q;
    clkb = issue || wr_q;
    ab = clkb ? addr_q[AW-1:0] : '0;
    db = wr_q ? wdat_q : '0;
  end
  // sequencing, counters and the read-latency tracker; counters sit at zero while idle
  always_comb begin
    state_d = idle ? ((start_save || start_load) ? REQ : IDLE)
            : state_q == REQ ? (gnt ? (op_save_q ? SAVE : LOAD) : REQ)
            : state_q == SAVE ? ((pop && pops_q == LAST) ? FIN : SAVE)
            : state_q == LOAD ? ((wr_q && addr_q == LAST) ? FIN : LOAD)
            : IDLE;
    op_save_d = idle ? start_save : op_save_q;
    addr_d = idle ? '0 : addr_q + (AW+1)'(issue || wr_q);
    pops_d = idle ? '0 : pops_q + (AW+1)'(pop);
    accs_d = idle ? '0 : accs_q + (AW+1)'(accept);
    vld_d = RD_LAT'({vld_q, issue});
    wr_d = accept;
    wdat_d = accept ? l_data : wdat_q;
  end
  // state registers
  always_ff @(posedge sys_clk or posedge reset)
    if (reset) begin
      state_q <= IDLE;
      op_save_q <= 1'b0;
      addr_q <= '0;
      pops_q <= '0;
      accs_q <= '0;
      vld_q <= '0;
      wr_q <= 1'b0;
      wdat_q <= '0;
    end else begin
      state_q <= state_d;
      op_save_q <= op_save_d;
      addr_q <= addr_d;
      pops_q <= pops_d;
      accs_q <= accs_d;
      vld_q <= vld_d;
      wr_q <= wr_d;
      wdat_q <= wdat_d;
    end
endmodule

// File: tb/tb_regfile_sstate.sv
// tb_regfile_sstate: randomized checks of two engines (RD_LAT 1 and 2) against a behavioural register-file model
module tb_regfile_sstate;
  logic sys_clk = 0, reset = 1, start_save = 0, start_load = 0, gnt = 0, s_ready = 0, l_valid = 0, preload = 0;
  logic [31:0] l_data = 0;
  logic busy [2], done [2], req [2], nweb [2], clkb [2], s_valid [2], l_ready [2];
  logic [5:0] ab [2];
  logic [31:0] db [2], qb [2], s_data [2];
  logic [31:0] rf [2][64];
  logic [31:0] pipe [2][2];
  logic [31:0] gold [2][64];
  logic [31:0] lq [2][$];
  int sidx [2] = '{default: 0}, widx [2] = '{default: 0}, ndone [2] = '{default: 0}, done_cyc [2] = '{default: 0};
  logic acc_prev [2] = '{default: 0}, psv [2] = '{default: 0}, psr [2] = '{default: 0};
  logic [31:0] psd [2];
  logic [31:0] w;
  logic ew;
  int checks = 0, errors = 0, cyc = 0, rdy_mode = 0, lk = 0, exp_done = 0;
  logic lv_on = 0, rnd_data = 0;

  always #5 sys_clk = ~sys_clk;

  regfile_sstate #(.RD_LAT(1), .FIFO_DEPTH(4)) u_dut0 (
    .sys_clk(sys_clk), .reset(reset), .start_save(start_save), .start_load(start_load),
    .busy(busy[0]), .done(done[0]), .req(req[0]), .gnt(gnt),
    .ab(ab[0]), .db(db[0]), .nweb(nweb[0]), .clkb(clkb[0]), .qb(qb[0]),
    .s_data(s_data[0]), .s_valid(s_valid[0]), .s_ready(s_ready),
    .l_data(l_data), .l_valid(l_valid), .l_ready(l_ready[0])
  );
  regfile_sstate #(.RD_LAT(2), .FIFO_DEPTH(4)) u_dut1 (
    .sys_clk(sys_clk), .reset(reset), .start_save(start_save), .start_load(start_load),
    .busy(busy[1]), .done(done[1]), .req(req[1]), .gnt(gnt),
    .ab(ab[1]), .db(db[1]), .nweb(nweb[1]), .clkb(clkb[1]), .qb(qb[1]),
    .s_data(s_data[1]), .s_valid(s_valid[1]), .s_ready(s_ready),
    .l_data(l_data), .l_valid(l_valid), .l_ready(l_ready[1])
  );

  assign qb[0] = pipe[0][0];
  assign qb[1] = pipe[1][1];

  // register files: write on a strobe with nweb low, read data returns after the instance latency
  always @(posedge sys_clk)
    for (int g = 0; g < 2; g++) begin
      if (preload) for (int k = 0; k < 64; k++) rf[g][k] <= 32'hA500_0000 + 32'(k);
      else if (clkb[g] && !nweb[g]) rf[g][ab[g]] <= db[g];
      pipe[g][0] <= rf[g][ab[g]];
      pipe[g][1] <= pipe[g][0];
    end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h at cycle %0d", tag, got, exp, cyc);
    end
  endtask

  // scoreboard: k-th accepted load word lands at address k one cycle later; saves stream the expected contents in order
  always @(negedge sys_clk) begin
    cyc++;
    for (int g = 0; g < 2; g++) begin
      if (preload) for (int k = 0; k < 64; k++) gold[g][k] = 32'hA500_0000 + 32'(k);
      ew = acc_prev[g] && !reset;
      chk("nweb", 64'(nweb[g]), 64'(!ew));
      if (ew) begin
        w = lq[g].pop_front();
        chk("wr_ab", 64'(ab[g]), 64'(widx[g]));
        chk("wr_db", 64'(db[g]), 64'(w));
        chk("wr_clkb", 64'(clkb[g]), 64'd1);
        gold[g][widx[g] & 63] = w;
        widx[g]++;
      end
      acc_prev[g] = l_valid && l_ready[g] && !reset;
      if (acc_prev[g]) lq[g].push_back(l_data);
      if (psv[g] && !psr[g] && !reset) begin
        chk("hold_valid", 64'(s_valid[g]), 64'd1);
        chk("hold_data", 64'(s_data[g]), 64'(psd[g]));
      end
      if (s_valid[g] && s_ready && !reset) begin
        chk("s_data", 64'(s_data[g]), 64'(gold[g][sidx[g] & 63]));
        sidx[g]++;
      end
      psv[g] = s_valid[g];
      psr[g] = s_ready;
      psd[g] = s_data[g];
      if (done[g]) begin
        ndone[g]++;
        done_cyc[g] = cyc;
        chk("words", 64'(sidx[g] + widx[g]), 64'd64);
        chk("one_op", 64'(sidx[g] == 0 || widx[g] == 0), 64'd1);
        sidx[g] = 0;
        widx[g] = 0;
      end
      if (reset) begin
        sidx[g] = 0;
        widx[g] = 0;
        acc_prev[g] = 0;
        lq[g].delete();
      end
    end
  end

  task automatic cycle();
    @(posedge sys_clk);
    #1;
    if (acc_prev[0]) begin
      lk++;
      l_data = rnd_data ? $urandom : 32'h1000 + 32'(lk);
    end
    l_valid = lv_on && ($urandom_range(2) != 0);
    s_ready = rdy_mode == 0 ? 1'b1 : rdy_mode == 1 ? (cyc % 4 == 0 || cyc % 4 == 3) : 1'($urandom_range(1));
  endtask

  task automatic chk_rst();
    for (int g = 0; g < 2; g++) begin
      chk("rst_ctl", 64'({busy[g], done[g], req[g], s_valid[g], l_ready[g], nweb[g], clkb[g]}), 64'b0000010);
      chk("rst_ab", 64'(ab[g]), 64'd0);
      chk("rst_db", 64'(db[g]), 64'd0);
      chk("rst_sdata", 64'(s_data[g]), 64'd0);
    end
  endtask

  task automatic op(input logic sv, input logic ld, input int gd, input int inj, input logic lat);
    int st;
    gnt = (gd == 0);
    start_save = sv;
    start_load = ld;
    st = cyc;
    cycle();
    start_save = 0;
    start_load = 0;
    chk("busy_req", 64'({busy[0], busy[1], req[0], req[1]}), 64'hF);
    for (int i = 1; i < gd; i++) cycle();
    gnt = 1;
    for (int i = 0; i < 600 && !(ndone[0] > exp_done && ndone[1] > exp_done); i++) begin
      start_load = (i == inj);
      cycle();
    end
    start_load = 0;
    chk("op_done", 64'(ndone[0] > exp_done && ndone[1] > exp_done), 64'd1);
    exp_done++;
    if (lat) begin
      chk("latency_rl1", 64'(done_cyc[0] - st - 1 <= 64 + 1 + 3), 64'd1);
      chk("latency_rl2", 64'(done_cyc[1] - st - 1 <= 64 + 2 + 3), 64'd1);
    end
    gnt = 0;
    lv_on = 0;
    repeat (4) cycle();
    chk("done_count0", 64'(ndone[0]), 64'(exp_done));
    chk("done_count1", 64'(ndone[1]), 64'(exp_done));
    chk("idle", 64'({busy[0], busy[1], req[0], req[1]}), 64'd0);
  endtask

  initial begin
    repeat (2) cycle();
    chk_rst();
    reset = 0;
    preload = 1;
    cycle();
    preload = 0;
    rdy_mode = 0;
    op(1, 0, 3, -1, 0);
    rdy_mode = 1;
    op(1, 0, $urandom_range(4), -1, 0);
    rnd_data = 0;
    lk = 0;
    l_data = 32'h1000;
    lv_on = 1;
    op(0, 1, $urandom_range(4), -1, 0);
    rdy_mode = 2;
    op(1, 0, $urandom_range(4), -1, 0);
    op(1, 1, 1, 10, 0);
    rdy_mode = 0;
    op(1, 0, 0, -1, 1);
    rnd_data = 1;
    lk = 0;
    l_data = $urandom;
    lv_on = 1;
    gnt = 1;
    start_load = 1;
    cycle();
    start_load = 0;
    for (int i = 0; i < 400 && widx[0] < 20; i++) cycle();
    chk("reach20", 64'(widx[0]), 64'd20);
    reset = 1;
    #1;
    chk_rst();
    lv_on = 0;
    gnt = 0;
    repeat (3) cycle();
    chk_rst();
    reset = 0;
    cycle();
    for (int g = 0; g < 2; g++)
      for (int k = 0; k < 64; k++) chk("rf_keep", 64'(rf[g][k]), 64'(gold[g][k]));
    rdy_mode = 2;
    op(1, 0, 2, -1, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
